// File: rtl/ud_mod_prescale_counter_pkg.sv
// Shared encodings for direction and mode inputs, plus the prescaler width helper.
package ud_mod_prescale_counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  // A PRESCALE of 1 still gets a 1-bit register so the prescaler has one code path.
  function automatic int pre_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/ud_mod_prescale_counter_tick_prescaler.sv
// Divides enabled cycles by PRESCALE and produces a tick on the last one.
// Holds its phase while en is low. clr restarts the period from zero.
module tick_prescaler
  import ud_mod_prescale_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = pre_width(PRESCALE);

  logic [PW-1:0] pre;

  assign tick = en && (pre == PW'(PRESCALE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (clr) begin
      pre <= '0;
    end else if (en) begin
      pre <= tick ? '0 : pre + PW'(1);
    end
  end

endmodule

// File: rtl/ud_mod_prescale_counter.sv
// Up/down modulo counter over 0..MAX_VAL with load, programmable step, wrap or saturate,
// and a built-in enable prescaler. Count and flags update one cycle after a tick or load.
module ud_mod_prescale_counter
  import ud_mod_prescale_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 255,
  parameter int STEP_W   = 4,
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  data,
  input  logic              u_d,
  input  logic              mode_sat,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              ovf,
  output logic              unf
);

  if (MAX_VAL >= (1 << WIDTH)) begin : g_bad_max
    $error("MAX_VAL must be below 2**WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("PRESCALE must be at least 1");
  end

  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MAX_VAL);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MAX_VAL + 1);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);

  logic             tick;
  logic [WIDTH:0]   c_ext;
  logic [WIDTH:0]   s_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] nxt;
  logic             nxt_ovf;
  logic             nxt_unf;
  logic [WIDTH-1:0] load_val;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_pre (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (load),
    .tick(tick)
  );

  assign c_ext    = {1'b0, count};
  assign s_ext    = (WIDTH + 1)'(step);
  assign sum      = c_ext + s_ext;
  assign load_val = (data > MAX_W) ? MAX_W : data;
  assign tc       = (u_d == DIR_UP) ? (count == MAX_W) : (count == '0);

  // All range checks happen one bit wider so the carry/borrow is never lost.
  always_comb begin
    nxt     = count;
    nxt_ovf = 1'b0;
    nxt_unf = 1'b0;
    if (u_d == DIR_UP) begin
      if (sum > MAX_EXT) begin
        nxt_ovf = 1'b1;
        nxt     = (mode_sat == MODE_SAT) ? MAX_W : WIDTH'(sum - MOD_EXT);
      end else begin
        nxt = WIDTH'(sum);
      end
    end else begin
      if (s_ext <= c_ext) begin
        nxt = WIDTH'(c_ext - s_ext);
      end else begin
        nxt_unf = 1'b1;
        nxt     = (mode_sat == MODE_SAT) ? '0 : WIDTH'(c_ext + MOD_EXT - s_ext);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (load) begin
      count <= load_val;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (tick) begin
      count <= nxt;
      ovf   <= nxt_ovf;
      unf   <= nxt_unf;
    end else begin
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ud_mod_prescale_counter.sv
// Bench: two counters (prescale 1 and 4) share stimulus and are checked against an arithmetic model.
module tb_ud_mod_prescale_counter;

  localparam int W   = 8;
  localparam int MAX = 9;
  localparam int SW  = 4;
  localparam int PS [2] = '{1, 4};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0, load = 1'b0, u_d = 1'b0, mode_sat = 1'b0;
  logic [W-1:0]  data = '0;
  logic [SW-1:0] step = '0;

  logic [W-1:0] cnt_o [2];
  logic         tc_o  [2];
  logic         ovf_o [2];
  logic         unf_o [2];

  int checks   = 0;
  int failures = 0;

  // Reference state: plain integers, prescaler seen as "enabled cycles since last tick/load".
  int m_cnt [2];
  int m_seen[2];
  bit m_ovf [2];
  bit m_unf [2];

  always #5 clk = ~clk;

  ud_mod_prescale_counter #(.WIDTH(W), .MAX_VAL(MAX), .STEP_W(SW), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .u_d(u_d),
    .mode_sat(mode_sat), .step(step), .count(cnt_o[0]), .tc(tc_o[0]),
    .ovf(ovf_o[0]), .unf(unf_o[0])
  );

  ud_mod_prescale_counter #(.WIDTH(W), .MAX_VAL(MAX), .STEP_W(SW), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .u_d(u_d),
    .mode_sat(mode_sat), .step(step), .count(cnt_o[1]), .tc(tc_o[1]),
    .ovf(ovf_o[1]), .unf(unf_o[1])
  );

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      m_ovf[i] = 1'b0;
      m_unf[i] = 1'b0;
      if (rst) begin
        m_cnt[i]  = 0;
        m_seen[i] = 0;
      end else if (load) begin
        m_cnt[i]  = (int'(data) > MAX) ? MAX : int'(data);
        m_seen[i] = 0;
      end else if (en) begin
        m_seen[i]++;
        if (m_seen[i] == PS[i]) begin
          m_seen[i] = 0;
          if (u_d) begin
            if (m_cnt[i] + int'(step) > MAX) begin
              m_ovf[i] = 1'b1;
              m_cnt[i] = mode_sat ? MAX : m_cnt[i] + int'(step) - (MAX + 1);
            end else begin
              m_cnt[i] = m_cnt[i] + int'(step);
            end
          end else begin
            if (int'(step) <= m_cnt[i]) begin
              m_cnt[i] = m_cnt[i] - int'(step);
            end else begin
              m_unf[i] = 1'b1;
              m_cnt[i] = mode_sat ? 0 : m_cnt[i] + (MAX + 1) - int'(step);
            end
          end
        end
      end
    end
  end

  function automatic bit model_tc(int i);
    return u_d ? (m_cnt[i] == MAX) : (m_cnt[i] == 0);
  endfunction

  // Every cycle, away from the edge: both DUTs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (int'(step) > MAX) begin
        failures++;
        $display("FAIL step_legal step=%0d max=%0d", step, MAX);
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (int'(cnt_o[i]) != m_cnt[i] || ovf_o[i] != m_ovf[i] || unf_o[i] != m_unf[i] ||
            tc_o[i] != model_tc(i) || int'(cnt_o[i]) > MAX) begin
          failures++;
          $display("FAIL model_cmp dut%0d t=%0t got cnt=%0d ovf=%0b unf=%0b tc=%0b exp cnt=%0d ovf=%0b unf=%0b tc=%0b",
                   i, $time, cnt_o[i], ovf_o[i], unf_o[i], tc_o[i], m_cnt[i], m_ovf[i], m_unf[i], model_tc(i));
        end
      end
    end
  end

  // Literal expectation applied to a DUT and to the model alike.
  task automatic chk(input string name, input int i, input int e_cnt, input bit e_ovf,
                     input bit e_unf, input bit e_tc);
    checks++;
    if (int'(cnt_o[i]) != e_cnt || ovf_o[i] != e_ovf || unf_o[i] != e_unf || tc_o[i] != e_tc ||
        m_cnt[i] != e_cnt || m_ovf[i] != e_ovf || m_unf[i] != e_unf) begin
      failures++;
      $display("FAIL %s dut%0d got cnt=%0d ovf=%0b unf=%0b tc=%0b model cnt=%0d exp cnt=%0d ovf=%0b unf=%0b tc=%0b",
               name, i, cnt_o[i], ovf_o[i], unf_o[i], tc_o[i], m_cnt[i], e_cnt, e_ovf, e_unf, e_tc);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set(input bit e, input bit l, input int d, input bit ud, input bit ms, input int s);
    en = e; load = l; data = W'(d); u_d = ud; mode_sat = ms; step = SW'(s);
  endtask

  initial begin
    #2;
    chk("reset_state", 0, 0, 0, 0, 1);
    chk("reset_state_p4", 1, 0, 0, 0, 1);
    cyc(2);
    rst = 1'b0;

    // Async reset mid-count at 5.
    set(0, 1, 4, 1, 0, 1); cyc();
    set(1, 0, 0, 1, 0, 1); cyc();
    chk("pre_rst_count", 0, 5, 0, 0, 0);
    u_d = 1'b0;
    #1 rst = 1'b1;
    #1 chk("async_rst", 0, 0, 0, 0, 1);
    rst = 1'b0;

    // Up wrap through MAX, then clamped load.
    set(0, 1, 7, 1, 0, 1); cyc();
    chk("load7", 0, 7, 0, 0, 0);
    set(1, 0, 0, 1, 0, 1);
    cyc(); chk("up8", 0, 8, 0, 0, 0);
    cyc(); chk("up9_tc", 0, 9, 0, 0, 1);
    cyc(); chk("wrap0_ovf", 0, 0, 1, 0, 0);
    cyc(); chk("up1_no_ovf", 0, 1, 0, 0, 0);
    set(1, 1, 200, 1, 0, 1); cyc();
    chk("load_clamp", 0, 9, 0, 0, 1);

    // Down underflow: wrap, saturate, saturate again at 0.
    set(0, 1, 2, 0, 0, 3); cyc();
    set(1, 0, 0, 0, 0, 3); cyc();
    chk("down_wrap", 0, 9, 0, 1, 0);
    set(0, 1, 2, 0, 1, 3); cyc();
    set(1, 0, 0, 0, 1, 3); cyc();
    chk("down_sat", 0, 0, 0, 1, 1);
    cyc(); chk("down_sat_again", 0, 0, 0, 1, 1);

    // Load beats a tick in the same cycle, then step 0 holds.
    set(1, 1, 3, 1, 0, 1); cyc();
    chk("load_wins", 0, 3, 0, 0, 0);
    set(1, 0, 0, 1, 0, 0); cyc(2);
    chk("step0_hold", 0, 3, 0, 0, 0);

    // Prescale 4: tick every 4th enabled cycle; a 2-cycle en gap delays it 2 cycles.
    set(1, 1, 0, 1, 0, 1); cyc();
    set(1, 0, 0, 1, 0, 1);
    cyc(3); chk("p4_wait", 1, 0, 0, 0, 0);
    cyc();  chk("p4_tick", 1, 1, 0, 0, 0);
    cyc();
    en = 1'b0; cyc(2);
    en = 1'b1; cyc(2);
    chk("p4_gap_wait", 1, 1, 0, 0, 0);
    cyc(); chk("p4_gap_tick", 1, 2, 0, 0, 0);

    // Random traffic; the negedge compare process checks every cycle.
    for (int n = 0; n < 10000; n++) begin
      set(($urandom % 4) != 0, ($urandom % 16) == 0, int'($urandom % 256),
          $urandom % 2, $urandom % 2, int'($urandom_range(0, MAX)));
      cyc();
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
